skf_sweep_checker: RTL and testbench
====================================

# skf_sweep_checker

Exhaustive sweep controller for a combinational or pipelined Skolem-function block with `N_IN` inputs and one output. The block has a start/busy/done handshake. It enumerates every input assignment once, drives each one into the Skolem function under test, and compares the returned bit against a built-in golden predicate. The golden predicate is the disequality invertibility condition for logical shift right: `out = v[N_IN-1] | (|v[N_IN-2:0]`)`. The controller counts mismatches and captures the first failing vector. It sits beside a Skolem-function instance in the self-check harness, and its results feed the regression status register.

## Interface
Parameters:
- `N_IN`, default 8: number of Skolem-function inputs. The legal range is 2..16.
- `SKF_LAT`, default 0: cycles from `skf_vec` to the matching `skf_out`. The legal range is 0..3.

Ports:
- `clk`, input, width 1: the single clock; the block is rising-edge only.
- `rst_n`, input, width 1: asynchronous, active-low reset.
- `start`, input, width 1: sweep request. It is sampled only in IDLE or DONE.
- `abort`, input, width 1: terminates a sweep in RUN or DRAIN.
- `skf_vec`, output, width `N_IN`: assignment driven to the function under test. Bit `N_IN-1` is the existential-side input (i7 at the default).
- `skf_out`, input, width 1: the output of the function under test.
- `busy`, output, width 1: high in RUN and DRAIN.
- `done`, output, width 1: high in DONE.
- `pass`, output, width 1: set on entry to DONE when `fail_count == 0`.
- `fail_count`, output, width `N_IN+1`: number of mismatches in the current or last sweep.
- `first_fail_vec`, output, width `N_IN`: the first mismatching assignment.
- `first_fail_valid`, output, width 1: `first_fail_vec` holds a captured vector.

## Operation
- There are four states: IDLE, RUN, DRAIN and DONE.
- **IDLE / DONE, start = 1:** go to RUN.
  - Clear `fail_count`, `first_fail_valid`, `first_fail_vec`, `pass`, `done`, and the compare pipeline.
  - Load the vector counter with 0.
- **RUN:**
  - Drive `skf_vec` = counter and push valid = 1 into a `SKF_LAT`-deep compare pipeline together with the vector.
  - The counter increments by 1 each cycle.
  - After driving `2^N_IN - 1`:
    - Go to DRAIN when `SKF_LAT > 0`.
    - Go directly to DONE when `SKF_LAT = 0`, once the last compare completes in that cycle.
- **DRAIN:** push valid = 0 for `SKF_LAT` cycles, then go to DONE.
- **Compare**, in any cycle where the pipeline output is valid:
  - The expected bit is the golden predicate applied to the delayed vector.
  - On a mismatch, `fail_count` increments by 1.
  - On a mismatch while `first_fail_valid = 0`, capture the delayed vector into `first_fail_vec` and set `first_fail_valid`.
- **Counter width and range:**
  - The counter is `N_IN+1` bits wide, so the terminal compare is on the value `2^N_IN - 1` and there is no wrap.
  - `fail_count` maximum is `2^N_IN`; no saturation is needed.
- **abort = 1 in RUN or DRAIN:**
  - Go to IDLE on the next edge and flush the pipeline valids.
  - `done` and `pass` stay 0.
  - `fail_count`, `first_fail_*` and `skf_vec` hold their partial values.
  - Compares already in flight are dropped.
- **Simultaneous events:**
  - `abort` has priority over completion.
  - `start` in RUN or DRAIN is ignored.
  - `start` and `abort` together in IDLE or DONE: `start` wins, because `abort` has no effect outside RUN and DRAIN.
- **Outside RUN:** `skf_vec` holds its last driven value.

## Timing
- **Reset values:** state = IDLE. All outputs are 0: `skf_vec`, `busy`, `done`, `pass`, `fail_count`, `first_fail_vec` and `first_fail_valid`. The pipeline valids are also 0.
- **Reset mid-sweep:** returns immediately to the reset values. No partial results are retained.
- **Start response:** `start` sampled high at edge k gives the following:
  - `busy = 1` and `skf_vec = 0` during cycle k+1.
  - Vector v is driven in cycle k+1+v.
  - The compare for v happens in cycle k+1+v+`SKF_LAT`, and the result is visible after the next edge.
  - `done = 1` and `busy = 0` from cycle k+1+`2^N_IN`+`SKF_LAT`.
  - `pass`, `fail_count` and `first_fail_*` are final in the same cycle that `done` rises.
- **Throughput:** one vector per cycle, with no stalls.
- **`done`:** a level, held until the next accepted `start` or until reset.

## Test plan
All scenarios use the default parameters unless stated.
1. **Correct DUT**, `SKF_LAT = 0`, `start` pulse at edge k.
   - `busy` high for cycles k+1..k+256, then `done = 1` and `pass = 1` at k+257.
   - `fail_count = 0`, `first_fail_valid = 0`.
2. **Stuck-at-1 DUT:** `fail_count = 1`, `first_fail_vec = 8'h00`, `first_fail_valid = 1`, `pass = 0`.
3. **Stuck-at-0 DUT:** `fail_count = 255`, `first_fail_vec = 8'h01`.
4. **Inverted-output DUT:** `fail_count = 256` (9'h100, width check), `first_fail_vec = 8'h00`.
5. **`SKF_LAT = 2`** with the correct function behind two register stages.
   - `pass = 1`.
   - `done` at k+259.
   - Repeat with a one-stage (mis-latency) model: `pass = 0` and `fail_count > 0`.
6. **Abort, start while busy, and reset.**
   - Assert `abort` at vector 100: IDLE next cycle, `done = 0`, `busy = 0`, `skf_vec` holds 100.
   - `start` during RUN is ignored, so the sweep length is unchanged.
   - `rst_n` low mid-sweep: all outputs are 0 asynchronously.
   - A new `start` in IDLE runs a full clean sweep.

Source files
------------

// File: rtl/skf_sweep_checker.sv
// Exhaustive sweep controller for a Skolem-function block: drives every input
// assignment, compares against the LSHR disequality invertibility condition.
module skf_sweep_checker #(
   parameter int N_IN    = 8,
   parameter int SKF_LAT = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] skf_vec,
   input  logic            skf_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   fail_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [1:0] DLAST = 2'((SKF_LAT > 0) ? SKF_LAT - 1 : 0);

   state_t          state, state_nxt;
   logic            start_acc, abort_acc, flush, push;
   logic            cmp_v, cmp_ok, expect_bit;
   logic [N_IN-1:0] cmp_vec;
   logic [1:0]      dcnt;

   assign start_acc = ((state == IDLE) || (state == DONE)) && start;
   assign abort_acc = ((state == RUN) || (state == DRAIN)) && abort;
   assign flush     = start_acc | abort_acc;
   assign push      = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = RUN;
         RUN: begin
            if (abort)               state_nxt = IDLE;
            else if (skf_vec == '1)  state_nxt = (SKF_LAT > 0) ? DRAIN : DONE;
         end
         DRAIN: begin
            if (abort)               state_nxt = IDLE;
            else if (dcnt == DLAST)  state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == DONE);
      pass = (state == DONE) && (fail_count == '0);
   end

   // Valid/vector delay line aligning each driven vector with its returned bit.
   generate
      if (SKF_LAT > 0) begin : g_pipe
         logic [SKF_LAT-1:0] pv;
         logic [N_IN-1:0]    pvec [SKF_LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pv <= '0;
               for (int unsigned i = 0; i < SKF_LAT; i++) pvec[i] <= '0;
            end else begin
               pvec[0] <= skf_vec;
               for (int unsigned i = 1; i < SKF_LAT; i++) pvec[i] <= pvec[i-1];
               if (flush) begin
                  pv <= '0;
               end else begin
                  pv[0] <= push;
                  for (int unsigned i = 1; i < SKF_LAT; i++) pv[i] <= pv[i-1];
               end
            end
         end

         assign cmp_v   = pv[SKF_LAT-1];
         assign cmp_vec = pvec[SKF_LAT-1];
      end else begin : g_nopipe
         assign cmp_v   = push;
         assign cmp_vec = skf_vec;
      end
   endgenerate

   // The compare landing in the abort cycle is dropped along with the in-flight ones.
   assign cmp_ok     = cmp_v && !abort_acc;
   assign expect_bit = cmp_vec[N_IN-1] | (|cmp_vec[N_IN-2:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skf_vec          <= '0;
         fail_count       <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         dcnt             <= '0;
      end else if (start_acc) begin
         skf_vec          <= '0;
         fail_count       <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         dcnt             <= '0;
      end else begin
         if ((state == RUN) && !abort && (skf_vec != '1)) skf_vec <= skf_vec + 1'b1;
         if (state == DRAIN) dcnt <= dcnt + 2'd1;
         if (cmp_ok && (expect_bit != skf_out)) begin
            fail_count <= fail_count + 1'b1;
            if (!first_fail_valid) begin
               first_fail_vec   <= cmp_vec;
               first_fail_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_skf_sweep_checker.sv
// Bench for skf_sweep_checker: one zero-latency and one two-stage instance,
// checked every cycle against a sweep-level model plus literal expectations.
module tb_skf_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       st [2];
   logic       ab [2];
   logic [7:0] vec [2];
   logic       so [2];
   logic       bsy [2];
   logic       dn [2];
   logic       ps [2];
   logic [8:0] fc [2];
   logic [7:0] ffv [2];
   logic       ffval [2];

   bit         err [2][256];
   bit         mislat = 1'b0;
   logic       s1, s2;

   int nchk = 0;
   int nerr = 0;

   // model state
   bit m_run [2];
   bit m_done [2];
   int mt [2];
   int m_vec [2];
   int m_fc [2];
   int m_ffv [2];
   bit m_ffval [2];

   always #5 clk = ~clk;

   skf_sweep_checker #(.N_IN(8), .SKF_LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .skf_vec(vec[0]),
      .skf_out(so[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .fail_count(fc[0]),
      .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0]));

   skf_sweep_checker #(.N_IN(8), .SKF_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .skf_vec(vec[1]),
      .skf_out(so[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .fail_count(fc[1]),
      .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1]));

   // Functions under test: ideal predicate is "assignment is non-zero", with an error mask.
   assign so[0] = (vec[0] != 8'd0) ^ err[0][vec[0]];
   always @(posedge clk) begin
      s1 <= (vec[1] != 8'd0) ^ err[1][vec[1]];
      s2 <= s1;
   end
   assign so[1] = mislat ? s1 : s2;

   function automatic int lat(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   // Whether the compare for vector v sees a wrong bit.
   function automatic bit fails(input int d, input int v);
      int nxt;
      if (d == 1 && mislat) begin
         nxt = (v < 255) ? v + 1 : 255;
         return (v != 0) != (nxt != 0);
      end
      return err[d][v];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      int t, upto, c, first;
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_run[d] <= 0; m_done[d] <= 0; mt[d] <= 0; m_vec[d] <= 0;
            m_fc[d] <= 0; m_ffv[d] <= 0; m_ffval[d] <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (!m_run[d]) begin
               if (st[d]) begin
                  m_run[d] <= 1; mt[d] <= 1; m_done[d] <= 0; m_vec[d] <= 0;
                  m_fc[d] <= 0; m_ffv[d] <= 0; m_ffval[d] <= 0;
               end
            end else if (ab[d]) begin
               m_run[d] <= 0;
            end else begin
               t = mt[d] + 1;
               upto = t - 2 - lat(d);
               c = 0;
               first = -1;
               for (int v = 0; v < 256; v++)
                  if (v <= upto && fails(d, v)) begin
                     c++;
                     if (first < 0) first = v;
                  end
               mt[d] <= t;
               m_vec[d] <= (t - 1 > 255) ? 255 : t - 1;
               m_fc[d] <= c;
               m_ffval[d] <= (first >= 0);
               m_ffv[d] <= (first >= 0) ? first : 0;
               if (t == 257 + lat(d)) begin
                  m_run[d] <= 0;
                  m_done[d] <= 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("busy%0d", d), bsy[d], m_run[d]);
         chk($sformatf("done%0d", d), dn[d], m_done[d]);
         chk($sformatf("pass%0d", d), ps[d], (m_done[d] && m_fc[d] == 0));
         chk($sformatf("vec%0d", d), vec[d], m_vec[d]);
         chk($sformatf("fail_count%0d", d), fc[d], m_fc[d]);
         chk($sformatf("ffv%0d", d), ffv[d], m_ffv[d]);
         chk($sformatf("ffvalid%0d", d), ffval[d], m_ffval[d]);
      end
   end

   // mode: 0 correct, 1 stuck-at-1, 2 stuck-at-0, 3 inverted, 4 random faults
   task automatic set_mode(input int d, input int mode);
      for (int v = 0; v < 256; v++) begin
         case (mode)
            0: err[d][v] = 0;
            1: err[d][v] = (v == 0);
            2: err[d][v] = (v != 0);
            3: err[d][v] = 1;
            default: err[d][v] = ($urandom_range(7) == 0);
         endcase
      end
   endtask

   task automatic sweep(input int d, input int abort_n, input bit noise, input bit with_abort,
                        output int done_n, output int busy_n);
      bit aborted;
      aborted = 0;
      done_n = -1;
      busy_n = 0;
      @(negedge clk);
      st[d] = 1; ab[d] = with_abort;
      @(negedge clk);
      st[d] = 0; ab[d] = 0;
      for (int n = 1; n <= 700; n++) begin
         if (dn[d]) begin
            done_n = n;
            break;
         end
         if (bsy[d]) busy_n++;
         if (n == abort_n && bsy[d]) begin
            ab[d] = 1;
            @(negedge clk);
            ab[d] = 0;
            aborted = 1;
            break;
         end
         if (noise && bsy[d] && $urandom_range(15) == 0) st[d] = 1;
         @(negedge clk);
         st[d] = 0;
      end
      if (done_n < 0 && !aborted) chk("sweep_timeout", 0, 1);
   endtask

   initial begin
      int dn_n, bz_n, d, mode, an;
      st[0] = 0; st[1] = 0; ab[0] = 0; ab[1] = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bsy[0], 0);
      chk("rst_fc", fc[0], 0);
      chk("rst_done2", dn[1], 0);
      rst_n = 1;
      @(negedge clk);

      set_mode(0, 0);
      sweep(0, -1, 0, 0, dn_n, bz_n);
      chk("ok_done_cycle", dn_n, 257);
      chk("ok_busy_cycles", bz_n, 256);
      chk("ok_pass", ps[0], 1);
      chk("ok_ffvalid", ffval[0], 0);

      set_mode(0, 1);
      sweep(0, -1, 0, 0, dn_n, bz_n);
      chk("sa1_fc", fc[0], 1);
      chk("sa1_ffv", ffv[0], 0);
      chk("sa1_ffvalid", ffval[0], 1);
      chk("sa1_pass", ps[0], 0);

      set_mode(0, 2);
      sweep(0, -1, 0, 0, dn_n, bz_n);
      chk("sa0_fc", fc[0], 255);
      chk("sa0_ffv", ffv[0], 1);

      set_mode(0, 3);
      sweep(0, -1, 0, 0, dn_n, bz_n);
      chk("inv_fc", fc[0], 256);
      chk("inv_ffv", ffv[0], 0);

      set_mode(1, 0);
      sweep(1, -1, 0, 0, dn_n, bz_n);
      chk("lat2_pass", ps[1], 1);
      chk("lat2_done_cycle", dn_n, 259);
      mislat = 1;
      sweep(1, -1, 0, 0, dn_n, bz_n);
      chk("mislat_pass", ps[1], 0);
      chk("mislat_fc_nonzero", (fc[1] != 0), 1);
      mislat = 0;

      set_mode(0, 2);
      sweep(0, 101, 0, 0, dn_n, bz_n);
      chk("abort_busy", bsy[0], 0);
      chk("abort_done", dn[0], 0);
      chk("abort_vec", vec[0], 100);
      chk("abort_fc", fc[0], 99);

      set_mode(0, 0);
      sweep(0, -1, 1, 1, dn_n, bz_n);
      chk("noise_done_cycle", dn_n, 257);

      @(negedge clk);
      st[0] = 1;
      @(negedge clk);
      st[0] = 0;
      repeat (50) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_busy", bsy[0], 0);
      chk("mid_rst_vec", vec[0], 0);
      chk("mid_rst_fc", fc[0], 0);
      @(negedge clk);
      rst_n = 1;
      sweep(0, -1, 0, 0, dn_n, bz_n);
      chk("post_rst_done_cycle", dn_n, 257);
      chk("post_rst_pass", ps[0], 1);

      for (int i = 0; i < 12; i++) begin
         d = $urandom_range(1);
         mode = $urandom_range(4);
         set_mode(d, mode);
         an = ($urandom_range(2) == 0) ? int'($urandom_range(1, 260)) : -1;
         sweep(d, an, $urandom_range(1), $urandom_range(1), dn_n, bz_n);
         repeat ($urandom_range(3)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
